// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg
//   Shared definitions for the frame sequencer slice: FSM state encoding,
//   default geometry parameters and the overrun counter width.
package frame_seq_pkg;

  localparam int unsigned FRAME_LEN_DEF = 1024;
  localparam int unsigned SAMPLE_W_DEF  = 8;
  localparam int unsigned OVR_CNT_W     = 16;

  localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = '1;

  // Encodings are visible on state_out, so they are fixed explicitly.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    HANDOFF = 2'd2
  } state_e;

endpackage

// File: rtl/frame_bank_ram.sv
// frame_bank_ram
//   Simple dual-port sample RAM holding two frame banks. The bank is the
//   address MSB. One write port, one read port with a 2-cycle registered
//   read (address registered into the array read, then an output register).
//   No reset: contents survive reset.
// Ports:
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address {bank, index}
//   wdata_i  : write data
//   raddr_i  : read address {bank, index}
//   rdata_o  : read data, valid 2 cycles after raddr_i is presented
module frame_bank_ram
  import frame_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 2 * FRAME_LEN_DEF,
  parameter int unsigned DATA_W = SAMPLE_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_stage_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rd_stage_q <= mem[raddr_i];
    rdata_q    <= rd_stage_q;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Captures a stream of audio samples into fixed-length frames using two
//   RAM banks (ping-pong). While the consumer owns one bank, the other is
//   filled. A completed frame is handed to the consumer only if it has
//   released its bank; otherwise the frame is dropped and refilled in place.
//
//   Optional feature: define FRAME_SEQ_OVERRUN_STATS_EN to build the
//   saturating dropped-frame counter; otherwise overrun_count_out is 0.
//
// Ports:
//   clk_in            : audio clock
//   rst_in            : synchronous active-high reset
//   record_in         : capture enable level
//   audio_valid_in    : single-cycle sample strobe
//   audio_in          : signed sample
//   frame_valid_out   : one-cycle pulse when a frame is handed off
//   frame_bank_out    : bank currently owned by the consumer
//   rd_addr_in        : consumer read index within its bank
//   rd_data_out       : sample at rd_addr_in, 2-cycle latency
//   done_in           : consumer releases its bank (single-cycle pulse)
//   busy_out          : consumer owns a bank
//   state_out         : FSM state (0 IDLE, 1 FILL, 2 HANDOFF)
//   overrun_count_out : number of dropped frames
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned SAMPLE_W  = SAMPLE_W_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          record_in,
  input  logic                          audio_valid_in,
  input  logic signed [SAMPLE_W-1:0]    audio_in,
  output logic                          frame_valid_out,
  output logic                          frame_bank_out,
  input  logic [$clog2(FRAME_LEN)-1:0]  rd_addr_in,
  output logic signed [SAMPLE_W-1:0]    rd_data_out,
  input  logic                          done_in,
  output logic                          busy_out,
  output logic [1:0]                    state_out,
  output logic [OVR_CNT_W-1:0]          overrun_count_out
);

  localparam int unsigned AW = $clog2(FRAME_LEN);

  state_e        state_q,     state_d;
  logic [AW-1:0] wr_idx_q,    wr_idx_d;
  logic          fill_bank_q, fill_bank_d;
  logic          cons_bank_q, cons_bank_d;
  logic          busy_q,      busy_d;
  logic          fvalid_q,    fvalid_d;

  logic          we;
  logic [AW:0]   waddr;
  logic [AW:0]   raddr;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    fill_bank_d = fill_bank_q;
    cons_bank_d = cons_bank_q;
    busy_d      = busy_q;
    fvalid_d    = 1'b0;
    we          = 1'b0;
    waddr       = {fill_bank_q, wr_idx_q};

    // Release of the consumer bank; an accepted handoff below re-sets busy.
    if (done_in) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (record_in) begin
          state_d  = FILL;
          wr_idx_d = '0;
        end
      end

      FILL: begin
        if (!record_in) begin
          state_d  = IDLE;
          wr_idx_d = '0;
        end else if (audio_valid_in) begin
          we       = 1'b1;
          wr_idx_d = wr_idx_q + AW'(1);
          // Index wraps to 0 naturally since FRAME_LEN is a power of two.
          if (&wr_idx_q) begin
            state_d = HANDOFF;
          end
        end
      end

      HANDOFF: begin
        state_d = FILL;
        if (!busy_q || done_in) begin
          fill_bank_d = ~fill_bank_q;
          cons_bank_d = fill_bank_q;
          fvalid_d    = 1'b1;
          busy_d      = 1'b1;
        end
        // A strobe here lands at index 0 of whichever bank fills next.
        if (audio_valid_in) begin
          we       = 1'b1;
          waddr    = {fill_bank_d, wr_idx_q};
          wr_idx_d = wr_idx_q + AW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        wr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      wr_idx_q    <= '0;
      fill_bank_q <= 1'b0;
      cons_bank_q <= 1'b1;
      busy_q      <= 1'b0;
      fvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      fill_bank_q <= fill_bank_d;
      cons_bank_q <= cons_bank_d;
      busy_q      <= busy_d;
      fvalid_q    <= fvalid_d;
    end
  end

`ifdef FRAME_SEQ_OVERRUN_STATS_EN
  logic [OVR_CNT_W-1:0] ovr_q;
  logic                 drop;

  assign drop = (state_q == HANDOFF) && busy_q && !done_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ovr_q <= '0;
    end else if (drop && (ovr_q != OVR_CNT_MAX)) begin
      ovr_q <= ovr_q + OVR_CNT_W'(1);
    end
  end

  assign overrun_count_out = ovr_q;
`else
  assign overrun_count_out = '0;
`endif

  // Reads only ever target the consumer bank, writes only the fill bank.
  assign raddr = {cons_bank_q, rd_addr_in};

  frame_bank_ram #(
    .DEPTH  (2 * FRAME_LEN),
    .DATA_W (SAMPLE_W)
  ) u_ram (
    .clk_i   (clk_in),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (audio_in),
    .raddr_i (raddr),
    .rdata_o (rd_data_out)
  );

  assign frame_valid_out = fvalid_q;
  assign frame_bank_out  = cons_bank_q;
  assign busy_out        = busy_q;
  assign state_out       = state_q;

endmodule
